wb_write_port: RTL and testbench

//  Writer side of the register file write port (wwreg/wdestReg/wbData): the MEM/WB pipeline register.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/wb_queue.sv | 85 ++++++++
 rtl/wb_write_port.sv | 97 +++++++++
 tb/tb_wb_write_port.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths and the writeback queue entry type for the register file write port.
package cpu_pkg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// FIFO of pending long-latency results with a destination-match kill port
// that invalidates stale entries when a younger pipeline write lands.
module wb_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          push,
    input  wb_entry_t     push_entry,
    input  logic          pop,
    input  logic          kill_en,
    input  logic [AW-1:0] kill_dest,
    output wb_entry_t     head,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t         mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              push_s;
    logic              pop_s;
    wb_entry_t         store_s;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return PW'(0);
        end else begin
            return ptr + PW'(1);
        end
    endfunction

    // Guard handshakes and apply the same-edge kill to the incoming entry
    always_comb begin
        push_s  = push && !full;
        pop_s   = pop && !empty;
        store_s = push_entry;
        if (kill_en && (push_entry.dest == kill_dest)) begin
            store_s.valid = 1'b0;
        end else begin
            store_s.valid = push_entry.valid;
        end
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && (mem_r[i].dest == kill_dest)) begin
                    mem_r[i].valid <= 1'b0;
                end
            end
            if (push_s) begin
                mem_r[wr_ptr_r] <= store_s;
                wr_ptr_r        <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));

endmodule

// File: rtl/wb_write_port.sv
// MEM/WB pipeline register merging in-order MEM results with queued
// long-latency results; pipeline writes win, with a one-cycle starvation stall.
module wb_write_port
    import cpu_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic [AW-1:0] mdestReg,
    input  logic [DW-1:0] mr,
    input  logic [DW-1:0] mdo,
    input  logic          lu_valid,
    input  logic [AW-1:0] lu_dest,
    input  logic [DW-1:0] lu_data,
    output logic          lu_ready,
    output logic          pipe_stall,
    output logic          wwreg,
    output logic [AW-1:0] wdestReg,
    output logic [DW-1:0] wbData
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t     head_s;
    wb_entry_t     push_entry_s;
    logic          full_s;
    logic          empty_s;
    logic          pipe_wr_s;
    logic          pop_s;
    logic          push_s;
    logic [SW-1:0] starve_r;

    // Slot arbitration: an r0 destination is treated as no pipeline write
    always_comb begin
        pipe_wr_s          = !pipe_stall && mwreg && (mdestReg != REG_ZERO);
        pop_s              = !pipe_wr_s && !empty_s;
        push_s             = lu_valid && lu_ready;
        push_entry_s.valid = (lu_dest != REG_ZERO);
        push_entry_s.dest  = lu_dest;
        push_entry_s.data  = lu_data;
    end

    wb_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clock     (clock),
        .resetn    (resetn),
        .push      (push_s),
        .push_entry(push_entry_s),
        .pop       (pop_s),
        .kill_en   (pipe_wr_s),
        .kill_dest (mdestReg),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // MEM/WB register: pipeline write, else queue head, else idle with held index/data
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wwreg    <= 1'b0;
            wdestReg <= REG_ZERO;
            wbData   <= {DW{1'b0}};
        end else if (pipe_wr_s) begin
            wwreg    <= 1'b1;
            wdestReg <= mdestReg;
            wbData   <= mm2reg ? mdo : mr;
        end else if (pop_s) begin
            wwreg    <= head_s.valid;
            wdestReg <= head_s.dest;
            wbData   <= head_s.data;
        end else begin
            wwreg    <= 1'b0;
        end
    end

    // Count slots denied to a non-empty queue; reaching the limit forces a drain cycle
    always_ff @(posedge clock) begin
        if (!resetn) begin
            starve_r <= SW'(0);
        end else if (empty_s || pop_s) begin
            starve_r <= SW'(0);
        end else if (pipe_wr_s) begin
            starve_r <= starve_r + SW'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

    assign pipe_stall = (starve_r == SW'(STARVE_LIMIT));
    assign lu_ready   = !full_s;

endmodule

// File: tb/tb_wb_write_port.sv
// Directed-vector bench for wb_write_port with hand-computed expectations.
module tb_wb_write_port;

    logic        clock = 1'b0;
    logic        resetn;
    logic        mwreg;
    logic        mm2reg;
    logic [4:0]  mdestReg;
    logic [31:0] mr;
    logic [31:0] mdo;
    logic        lu_valid;
    logic [4:0]  lu_dest;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        pipe_stall;
    logic        wwreg;
    logic [4:0]  wdestReg;
    logic [31:0] wbData;

    int n_checks = 0;
    int n_fail   = 0;

    wb_write_port #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .mwreg     (mwreg),
        .mm2reg    (mm2reg),
        .mdestReg  (mdestReg),
        .mr        (mr),
        .mdo       (mdo),
        .lu_valid  (lu_valid),
        .lu_dest   (lu_dest),
        .lu_data   (lu_data),
        .lu_ready  (lu_ready),
        .pipe_stall(pipe_stall),
        .wwreg     (wwreg),
        .wdestReg  (wdestReg),
        .wbData    (wbData)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn = 1'b0; mwreg = 1'b1; mm2reg = 1'b0; mdestReg = 5'd3;
        mr = 32'h0; mdo = 32'h0; lu_valid = 1'b0; lu_dest = 5'd0; lu_data = 32'h0;

        // 1. reset
        tick(); tick();
        check("rst_wwreg", {31'd0, wwreg}, 32'd0);
        check("rst_wdest", {27'd0, wdestReg}, 32'd0);
        check("rst_wbdata", wbData, 32'h0);
        check("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
        check("rst_stall", {31'd0, pipe_stall}, 32'd0);

        // 2. pipeline ALU then load write
        resetn = 1'b1; mwreg = 1'b1; mm2reg = 1'b0; mdestReg = 5'd3; mr = 32'h0000_1234;
        tick();
        check("alu_wwreg", {31'd0, wwreg}, 32'd1);
        check("alu_wdest", {27'd0, wdestReg}, 32'd3);
        check("alu_data", wbData, 32'h0000_1234);
        mm2reg = 1'b1; mdo = 32'hDEAD_BEEF;
        tick();
        check("load_data", wbData, 32'hDEAD_BEEF);

        // 3. LU result fills an idle slot, no bypass
        mwreg = 1'b0; mm2reg = 1'b0;
        lu_valid = 1'b1; lu_dest = 5'd5; lu_data = 32'hA000_00AA;
        tick();
        check("lu_nobypass", {31'd0, wwreg}, 32'd0);
        lu_valid = 1'b0;
        tick();
        check("lu_wwreg", {31'd0, wwreg}, 32'd1);
        check("lu_wdest", {27'd0, wdestReg}, 32'd5);
        check("lu_data", wbData, 32'hA000_00AA);

        // 4. starvation guard
        mwreg = 1'b1; mdestReg = 5'd10; mr = 32'h100;
        lu_valid = 1'b1; lu_dest = 5'd6; lu_data = 32'h66;
        tick();
        check("st_ready1", {31'd0, lu_ready}, 32'd1);
        mdestReg = 5'd11; mr = 32'h101; lu_dest = 5'd8; lu_data = 32'h88;
        tick();
        check("st_full", {31'd0, lu_ready}, 32'd0);
        check("st_wdest11", {27'd0, wdestReg}, 32'd11);
        check("st_stall1", {31'd0, pipe_stall}, 32'd0);
        lu_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            mdestReg = 5'(10 + i); mr = 32'h100 + 32'(i);
            tick();
            check("st_wdest", {27'd0, wdestReg}, 32'(10 + i));
            check("st_stall", {31'd0, pipe_stall}, (i == 4) ? 32'd1 : 32'd0);
        end
        mdestReg = 5'd15; mr = 32'h105;
        tick();
        check("st_pop_wwreg", {31'd0, wwreg}, 32'd1);
        check("st_pop_wdest", {27'd0, wdestReg}, 32'd6);
        check("st_pop_data", wbData, 32'h66);
        check("st_stall_off", {31'd0, pipe_stall}, 32'd0);
        tick();
        check("st_held_wdest", {27'd0, wdestReg}, 32'd15);
        check("st_held_data", wbData, 32'h105);
        mwreg = 1'b0;
        tick();
        check("st_drain_wdest", {27'd0, wdestReg}, 32'd8);
        check("st_drain_data", wbData, 32'h88);

        // 5. WAW kill of a queued entry
        lu_valid = 1'b1; lu_dest = 5'd7; lu_data = 32'h1111_1111;
        tick();
        lu_valid = 1'b0; mwreg = 1'b1; mdestReg = 5'd7; mr = 32'h2222_2222;
        tick();
        check("kill_pipe_wdest", {27'd0, wdestReg}, 32'd7);
        check("kill_pipe_data", wbData, 32'h2222_2222);
        mwreg = 1'b0;
        tick();
        check("kill_pop_wwreg", {31'd0, wwreg}, 32'd0);
        check("kill_empty", {31'd0, lu_ready}, 32'd1);

        // same-edge kill of an entry being accepted
        lu_valid = 1'b1; lu_dest = 5'd12; lu_data = 32'hCC;
        mwreg = 1'b1; mdestReg = 5'd12; mr = 32'h1C;
        tick();
        check("skill_pipe_data", wbData, 32'h1C);
        lu_valid = 1'b0; mwreg = 1'b0;
        tick();
        check("skill_pop_wwreg", {31'd0, wwreg}, 32'd0);

        // 6. r0 pipeline write yields the slot; r0 LU entry is invalid
        lu_valid = 1'b1; lu_dest = 5'd9; lu_data = 32'h99;
        tick();
        lu_valid = 1'b0; mwreg = 1'b1; mdestReg = 5'd0; mr = 32'hBAD;
        tick();
        check("r0_slot_wwreg", {31'd0, wwreg}, 32'd1);
        check("r0_slot_wdest", {27'd0, wdestReg}, 32'd9);
        check("r0_slot_data", wbData, 32'h99);
        mwreg = 1'b0; lu_valid = 1'b1; lu_dest = 5'd0; lu_data = 32'h55;
        tick();
        lu_valid = 1'b0;
        tick();
        check("lu_r0_wwreg", {31'd0, wwreg}, 32'd0);

        // reset with two entries queued
        mwreg = 1'b1; mdestReg = 5'd2; mr = 32'h2;
        lu_valid = 1'b1; lu_dest = 5'd20; lu_data = 32'h20;
        tick();
        lu_dest = 5'd21; lu_data = 32'h21;
        tick();
        check("q2_full", {31'd0, lu_ready}, 32'd0);
        resetn = 1'b0; mwreg = 1'b0; lu_valid = 1'b0;
        tick();
        check("mid_rst_ready", {31'd0, lu_ready}, 32'd1);
        check("mid_rst_wwreg", {31'd0, wwreg}, 32'd0);
        resetn = 1'b1;
        tick();
        check("post_rst_wwreg1", {31'd0, wwreg}, 32'd0);
        tick();
        check("post_rst_wwreg2", {31'd0, wwreg}, 32'd0);
        check("post_rst_ready", {31'd0, lu_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
